btn_event: RTL and testbench
============================

BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 Parameter BTN_WIDTH, default 5: number of independent button channels.
REQ-002 Parameter CNT_WIDTH, default 16: width of the per-channel hold counter.
REQ-003 Parameter LONG_CNT, default 16'd6000: cycles from press to long-press event; legal range 2..2^CNT_WIDTH-1.
REQ-004 Parameter REPEAT_CNT, default 16'd1500: cycles between auto-repeat events; legal range 2..2^CNT_WIDTH-1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 btn_in  input  BTN_WIDTH  debounced, synchronous button levels; 1 = pressed.
REQ-008 press_pulse  output  BTN_WIDTH  one-cycle pulse per channel on press.
REQ-009 release_pulse  output  BTN_WIDTH  one-cycle pulse per channel on release.
REQ-010 click_pulse  output  BTN_WIDTH  one-cycle pulse on release before the long-press threshold.
REQ-011 long_pulse  output  BTN_WIDTH  one-cycle pulse when the long-press threshold is reached.
REQ-012 repeat_pulse  output  BTN_WIDTH  one-cycle pulse every REPEAT_CNT cycles after long_pulse while the button stays held.
REQ-013 held  output  BTN_WIDTH  level; 1 while the channel is in state PRESSED or HELD.

Function
REQ-014 Each channel i shall run an independent FSM {IDLE, PRESSED, HELD} with its own CNT_WIDTH counter; channels shall not interact.
REQ-015 All outputs shall be registered; each event pulse shall be high for exactly one cycle, after the edge that caused it.
REQ-016 IDLE, btn_in[i]=1: next state PRESSED, counter <= 0, press_pulse[i] <= 1.
REQ-017 IDLE, btn_in[i]=0: stay IDLE, counter holds 0.
REQ-018 PRESSED, btn_in[i]=0: next state IDLE, release_pulse[i] <= 1, click_pulse[i] <= 1, counter <= 0.
REQ-019 PRESSED, btn_in[i]=1, counter == LONG_CNT-1: next state HELD, long_pulse[i] <= 1, counter <= 0.
REQ-020 PRESSED, btn_in[i]=1, otherwise: counter <= counter+1.
REQ-021 HELD, btn_in[i]=0: next state IDLE, release_pulse[i] <= 1, click_pulse[i] stays 0, counter <= 0.
REQ-022 HELD, btn_in[i]=1, counter == REPEAT_CNT-1: repeat_pulse[i] <= 1, counter <= 0.
REQ-023 HELD, btn_in[i]=1, otherwise: counter <= counter+1.
REQ-024 Release priority: a sampled btn_in[i]=0 on the threshold cycle shall produce a release (and a click from PRESSED), never long_pulse or repeat_pulse.
REQ-025 Timing: with the press sampled at edge E0, long_pulse shall assert after edge E0+LONG_CNT, and repeat_pulse after edges E0+LONG_CNT+k*REPEAT_CNT, k>=1.
REQ-026 The counter shall never wrap; the legal parameter ranges guarantee compare-and-clear happens before overflow.
REQ-027 held[i] shall be registered and equal to (next state != IDLE), so it rises with press_pulse[i] and falls with release_pulse[i].
REQ-028 Events on different channels in the same cycle shall all be reported in that cycle.

Reset
REQ-029 While rst=1 at a rising edge: all FSMs go to IDLE, all counters to 0, all outputs to 0. rst has priority over btn_in.
REQ-030 A button held through reset shall produce press_pulse on the first edge with rst=0; a reset during PRESSED or HELD shall produce no release_pulse.

Verification (bench parameters LONG_CNT=8, REPEAT_CNT=4, BTN_WIDTH=5)
REQ-031 Reset hold: rst=1 for 2 cycles with btn_in=5'b11111 -> all outputs 0; on the first edge with rst=0, press_pulse=5'b11111 and held=5'b11111.
REQ-032 Click: btn_in[0] high for 3 edges, then low -> press_pulse[0] at E0; release_pulse[0] and click_pulse[0] at E3; long_pulse never asserts.
REQ-033 Long and repeat: btn_in[2] high for edges E0..E19, low at E20 -> long_pulse[2] at E8; repeat_pulse[2] at E12 and E16; release_pulse[2] at E20 with no repeat and no click.
REQ-034 Threshold boundary: btn_in[1] high for E0..E7, low at E8 -> click_pulse[1] and release_pulse[1] at E8; long_pulse[1]=0 throughout.
REQ-035 Concurrency: channel 3 in HELD while btn_in[4] rises on a channel-3 repeat edge -> repeat_pulse[3] and press_pulse[4] in the same cycle; channel 3 cadence unchanged.
REQ-036 Mid-operation reset: rst=1 for 1 cycle while channel 2 is HELD and btn_in[2] stays 1 -> outputs 0 during reset; the next edge gives press_pulse[2] and the long_pulse timing restarts from that edge.

Source files
------------

// File: rtl/btn_event.sv
// Per-channel button event generator: press, release, click, long-press, auto-repeat.
// Latency: every output is registered and changes one cycle after the sampling edge.
// Backpressure: none; events are single-cycle pulses that the consumer must take when they occur.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst           synchronous active-high reset; beats btn_in
//   btn_in        debounced button levels, 1 = pressed
//   press_pulse   one cycle on press
//   release_pulse one cycle on release
//   click_pulse   one cycle on release before the long-press threshold
//   long_pulse    one cycle when the long-press threshold is reached
//   repeat_pulse  one cycle every REPEAT_CNT cycles after long_pulse while held
//   held          level; 1 while the channel is PRESSED or HELD
module btn_event #(
  parameter int BTN_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16,
  parameter int LONG_CNT   = 6000,
  parameter int REPEAT_CNT = 1500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [BTN_WIDTH-1:0] press_pulse,
  output logic [BTN_WIDTH-1:0] release_pulse,
  output logic [BTN_WIDTH-1:0] click_pulse,
  output logic [BTN_WIDTH-1:0] long_pulse,
  output logic [BTN_WIDTH-1:0] repeat_pulse,
  output logic [BTN_WIDTH-1:0] held
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  // Compare against N-1 because the counter is cleared on the press/threshold
  // edge itself, so N edges later it reads N-1.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CNT - 1);

  logic [1:0]           state [BTN_WIDTH];
  logic [CNT_WIDTH-1:0] cnt   [BTN_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTN_WIDTH; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
      press_pulse   <= '0;
      release_pulse <= '0;
      click_pulse   <= '0;
      long_pulse    <= '0;
      repeat_pulse  <= '0;
      held          <= '0;
    end else begin
      for (int i = 0; i < BTN_WIDTH; i++) begin
        // Pulses default low every cycle; branches below raise them for one cycle.
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
        click_pulse[i]   <= 1'b0;
        long_pulse[i]    <= 1'b0;
        repeat_pulse[i]  <= 1'b0;

        case (state[i])
          S_IDLE: begin
            cnt[i] <= '0;
            if (btn_in[i]) begin
              state[i]       <= S_PRESSED;
              press_pulse[i] <= 1'b1;
              held[i]        <= 1'b1;
            end else begin
              held[i] <= 1'b0;
            end
          end

          S_PRESSED: begin
            // Release is tested first so a release on the threshold edge wins.
            if (!btn_in[i]) begin
              state[i]         <= S_IDLE;
              cnt[i]           <= '0;
              release_pulse[i] <= 1'b1;
              click_pulse[i]   <= 1'b1;
              held[i]          <= 1'b0;
            end else if (cnt[i] == LONG_LAST) begin
              state[i]      <= S_HELD;
              cnt[i]        <= '0;
              long_pulse[i] <= 1'b1;
              held[i]       <= 1'b1;
            end else begin
              cnt[i]  <= cnt[i] + 1'b1;
              held[i] <= 1'b1;
            end
          end

          S_HELD: begin
            if (!btn_in[i]) begin
              state[i]         <= S_IDLE;
              cnt[i]           <= '0;
              release_pulse[i] <= 1'b1;
              held[i]          <= 1'b0;
            end else if (cnt[i] == REPEAT_LAST) begin
              cnt[i]          <= '0;
              repeat_pulse[i] <= 1'b1;
              held[i]         <= 1'b1;
            end else begin
              cnt[i]  <= cnt[i] + 1'b1;
              held[i] <= 1'b1;
            end
          end

          default: begin
            // Unreachable encoding: recover quietly to IDLE.
            state[i] <= S_IDLE;
            cnt[i]   <= '0;
            held[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_event.sv
module tb_btn_event;

  localparam int W = 5;
  localparam int L = 8;
  localparam int R = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] btn_in;
  logic [W-1:0] press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

  btn_event #(
    .BTN_WIDTH (W),
    .CNT_WIDTH (16),
    .LONG_CNT  (L),
    .REPEAT_CNT(R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a channel is "down" from its press edge; events follow from
  // the number of edges elapsed since that press.
  bit     down [W];
  int     t0   [W];
  int     edge_n = 0;
  logic [W-1:0] e_press, e_rel, e_click, e_long, e_rep, e_held;

  function automatic logic [6*W-1:0] obs_vec();
    return {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};
  endfunction

  function automatic logic [6*W-1:0] exp_vec();
    return {e_press, e_rel, e_click, e_long, e_rep, e_held};
  endfunction

  task automatic tick(input logic [W-1:0] b, input logic r);
    int d;
    @(negedge clk);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    edge_n++;
    e_press = '0; e_rel = '0; e_click = '0; e_long = '0; e_rep = '0;
    for (int i = 0; i < W; i++) begin
      d = edge_n - t0[i];
      if (r) begin
        down[i] = 1'b0;
      end else if (!down[i] && b[i]) begin
        down[i]    = 1'b1;
        t0[i]      = edge_n;
        e_press[i] = 1'b1;
      end else if (down[i] && !b[i]) begin
        down[i]    = 1'b0;
        e_rel[i]   = 1'b1;
        e_click[i] = (d <= L);
      end else if (down[i] && b[i]) begin
        e_long[i] = (d == L);
        e_rep[i]  = (d > L) && (((d - L) % R) == 0);
      end
      e_held[i] = down[i];
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      tick(5'b11111, 1'b1);
      n_checks++;
      if (obs_vec() !== '0) $display("FAIL reset_hold: got %h expected 0", obs_vec());
      else n_pass++;
    end
    tick(5'b11111, 1'b0);
    n_checks++;
    if (press_pulse !== 5'b11111 || held !== 5'b11111)
      $display("FAIL reset_release: press=%b held=%b expected 11111/11111", press_pulse, held);
    else n_pass++;
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
    else n_pass++;
    tick(5'b00000, 1'b0);
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_click();
    logic any_long = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick((k < 3) ? 5'b00001 : 5'b00000, 1'b0);
      any_long |= long_pulse[0];
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL click_step%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else n_pass++;
      if (k == 3) begin
        n_checks++;
        if ({release_pulse[0], click_pulse[0]} !== 2'b11)
          $display("FAIL click_E3: rel/click=%b%b expected 11", release_pulse[0], click_pulse[0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (any_long !== 1'b0) $display("FAIL click_nolong: saw long_pulse=%b expected 0", any_long);
    else n_pass++;
  endtask

  task automatic test_long_repeat();
    logic [20:0] seen_long = '0, seen_rep = '0;
    for (int k = 0; k <= 20; k++) begin
      tick((k < 20) ? 5'b00100 : 5'b00000, 1'b0);
      seen_long[k] = long_pulse[2];
      seen_rep[k]  = repeat_pulse[2];
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL longrep_E%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else n_pass++;
      if (k == 20) begin
        n_checks++;
        if ({release_pulse[2], click_pulse[2], repeat_pulse[2]} !== 3'b100)
          $display("FAIL longrep_release: rel/click/rep=%b%b%b expected 100",
                   release_pulse[2], click_pulse[2], repeat_pulse[2]);
        else n_pass++;
      end
    end
    n_checks++;
    if (seen_long !== 21'h000100) $display("FAIL long_edges: got %h expected 000100", seen_long);
    else n_pass++;
    n_checks++;
    if (seen_rep !== 21'h011000) $display("FAIL repeat_edges: got %h expected 011000", seen_rep);
    else n_pass++;
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_threshold();
    logic any_long = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick((k < 8) ? 5'b00010 : 5'b00000, 1'b0);
      any_long |= long_pulse[1];
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL thresh_E%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({release_pulse[1], click_pulse[1], any_long} !== 3'b110)
      $display("FAIL thresh_E8: rel/click/anylong=%b%b%b expected 110",
               release_pulse[1], click_pulse[1], any_long);
    else n_pass++;
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_concurrency();
    logic [W-1:0] b;
    for (int k = 0; k <= 20; k++) begin
      b = 5'b01000;
      if (k >= 12) b[4] = 1'b1;
      tick(b, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL conc_E%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else n_pass++;
      if (k == 12 || k == 16 || k == 20) begin
        n_checks++;
        if (repeat_pulse[3] !== 1'b1 || (k == 12 && press_pulse[4] !== 1'b1))
          $display("FAIL conc_rep_E%0d: rep3=%b press4=%b expected 1/1", k, repeat_pulse[3], press_pulse[4]);
        else n_pass++;
      end
    end
    tick(5'b00000, 1'b0);
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 10; k++) tick(5'b00100, 1'b0);
    tick(5'b00100, 1'b1);
    n_checks++;
    if (obs_vec() !== '0) $display("FAIL midrst_zero: got %h expected 0", obs_vec());
    else n_pass++;
    for (int k = 0; k <= 9; k++) begin
      tick(5'b00100, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL midrst_E%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else n_pass++;
      if (k == 0 || k == 8) begin
        n_checks++;
        if ((k == 0 && press_pulse[2] !== 1'b1) || (k == 8 && long_pulse[2] !== 1'b1))
          $display("FAIL midrst_evt_E%0d: press=%b long=%b", k, press_pulse[2], long_pulse[2]);
        else n_pass++;
      end
    end
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] b = '0;
    logic         r;
    int           errs = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
      r = ($urandom_range(0, 299) == 0);
      tick(b, r);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        errs++;
        if (errs <= 10) $display("FAIL random_%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end else n_pass++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    for (int i = 0; i < W; i++) begin
      down[i] = 1'b0;
      t0[i]   = 0;
    end
    e_press = '0; e_rel = '0; e_click = '0; e_long = '0; e_rep = '0; e_held = '0;
    test_reset();
    test_click();
    test_long_repeat();
    test_threshold();
    test_concurrency();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
